// File: rtl/clock_period_meter.sv
// Measures period and high time of a divided clock in clk_in cycles,
// with a per-period strobe and a stall timeout.
module clock_period_meter #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = (2 ** CNT_W) - 1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             div_in,
   input  logic             clear,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             period_stb,
   output logic             valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic {
      IDLE,
      MEAS
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             period_stb_q, period_stb_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             div_q, div_d;
   logic             rise, fall;

   assign rise = div_in & ~div_q;
   assign fall = ~div_in & div_q;

   // State and result registers; div_q resets high so a level-high input never looks like an edge.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         period_q     <= '0;
         high_q       <= '0;
         period_stb_q <= 1'b0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
         div_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         high_q       <= high_d;
         period_stb_q <= period_stb_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
         div_q        <= div_d;
      end
   end

   // Next-state: clear > rise > timeout > fall. The first rise after IDLE only arms.
   always_comb begin
      state_d      = state_q;
      cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      period_d     = period_q;
      high_d       = high_q;
      period_stb_d = 1'b0;
      valid_d      = valid_q;
      timeout_d    = timeout_q;
      div_d        = div_in;

      if (clear) begin
         state_d   = IDLE;
         cnt_d     = '0;
         period_d  = '0;
         high_d    = '0;
         valid_d   = 1'b0;
         timeout_d = 1'b0;
      end else if (rise) begin
         cnt_d = CNT_ONE;
         if (state_q == IDLE) begin
            state_d = MEAS;
         end else begin
            period_d     = cnt_q;
            period_stb_d = 1'b1;
            valid_d      = 1'b1;
            timeout_d    = 1'b0;
         end
      end else if (state_q == MEAS) begin
         if (cnt_q == TIMEOUT_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            valid_d   = 1'b0;
            period_d  = '0;
            high_d    = '0;
         end else if (fall) begin
            high_d = cnt_q;
         end
      end
   end

   assign period_out = period_q;
   assign high_out   = high_q;
   assign period_stb = period_stb_q;
   assign valid      = valid_q;
   assign timeout    = timeout_q;

endmodule
